bcd_display_sched: RTL and testbench
====================================

# bcd_display_sched

Round-robin scheduler that shares one two-digit decimal display path (tens/ones BCD digits feeding the seven-segment decoders on HEX1/HEX0) among `N_REQ` requesters. Each requester presents a binary value with a req/ack handshake. The block grants one requester at a time and captures its value. It converts the value to two BCD digits with a sequential subtract-by-10 engine, then holds the result on the display outputs for a minimum dwell time before serving the next requester.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 7: requester value width in bits, 4..8.
- `HOLD_CYCLES`, default 4: minimum dwell after each result, in cycles. Must be ≥1.
- `CLOCK_50`, input, 1: single clock; all state updates on the rising edge.
- `KEY0`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: request bit per requester. Held high until ack.
- `val`, input, N_REQ*W: value of requester i at `[i*W +: W]`, unsigned. Must be stable while `req[i]` is high.
- `ack`, output, N_REQ: one-cycle pulse to the served requester.
- `grant_id`, output, clog2(N_REQ): index of the current or last granted requester.
- `tens`, output, 4: BCD tens digit, registered.
- `ones`, output, 4: BCD ones digit, registered.
- `ovf`, output, 1: last value was >99, so the display saturated.
- `done`, output, 1: one-cycle strobe when `tens`/`ones`/`ovf` update.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, CONV and HOLD.
- **IDLE**
  - If any `req` bit is high, select the first set bit scanning from `ptr` upward, modulo N_REQ.
  - On that edge: capture `val[g]` into the work register, clear the tens counter, set `grant_id` = g, set `ptr` = (g+1) mod N_REQ, and go to CONV.
  - If no `req` bit is high, stay in IDLE.
- **CONV**, once per cycle:
  - If the captured value is >99: set `tens`=9, `ones`=9, `ovf`=1, and go to HOLD. This takes exactly one cycle in CONV.
  - Else if work ≥ 10: work −= 10 and tens counter += 1.
  - Else: `tens` ← tens counter, `ones` ← work[3:0], `ovf` ← 0, and go to HOLD.
  - On the CONV→HOLD edge, `done` and `ack[g]` are asserted for the following cycle.
- **HOLD**: stay exactly HOLD_CYCLES cycles, counted from entry, then go to IDLE.
- Arithmetic: the work register is W bits and the tens counter is 4 bits. Neither can overflow, because values ≤99 need ≤9 subtractions.
- `tens`, `ones` and `ovf` hold their last result until the next `done`. They never show intermediate values.
- Requester rules:
  - `req` dropped before grant: the request is not served and produces no ack.
  - `req` still high after its ack: treated as a new request. Because of the `ptr` advance, it is served only after the other pending requesters.
  - Changes to `val` after capture are ignored.
- Only one `ack` bit is ever high at a time.

## Timing
- Reset, asynchronous on `KEY0`=0, applies immediately without waiting for an edge:
  - State goes to IDLE and `ptr`=0.
  - Outputs go to `tens`=0, `ones`=0, `ovf`=0, `done`=0, `ack`=0, `grant_id`=0, `busy`=0.
- Reset mid-CONV or mid-HOLD abandons the request with no ack. Operation resumes on the first edge after `KEY0` returns high.
- Latency: cycle 0 is the IDLE cycle in which `req` is sampled.
  - For value v ≤ 99, `done`/`ack` are high in cycle floor(v/10)+2.
  - For v > 99, `done`/`ack` are high in cycle 2.
- `busy` is high from cycle 1 through the last HOLD cycle.
- Next sample: HOLD spans cycles L .. L+HOLD_CYCLES−1, where L is the `done` cycle. IDLE is cycle L+HOLD_CYCLES, and a new `req` may be sampled there.
- Simultaneous requests are resolved purely by round-robin from `ptr`. `req` changes during CONV or HOLD have no effect until IDLE.

## Test plan
- **Reset values:** assert `KEY0`=0 mid-stream → all outputs 0 with no clock edge. Release, no `req` → `busy`=0 indefinitely.
- **Single request:** `req[0]`=1, `val[0]`=57, sampled in cycle 0 → `done`=`ack[0]`=1 in cycle 7 only. `tens`=5, `ones`=7, `ovf`=0, `grant_id`=0. `busy` falls after 4 HOLD cycles.
- **Boundary values on `req[2]`:** check each value's result and `done` cycle.
  - 0 → 0/0, cycle 2.
  - 9 → 0/9, cycle 2.
  - 10 → 1/0, cycle 3.
  - 99 → 9/9, cycle 11.
- **Overflow:** 100 and 127 → `tens`=9, `ones`=9, `ovf`=1, `done` in cycle 2. A following value of 42 → `ovf`=0, digits 4/2.
- **Fairness:** all four `req` held high continuously → `grant_id` sequence 0,1,2,3,0,1. No requester is granted twice before the others. Exactly one `ack` per grant.
- **Abort:** reset asserted in cycle 3 of `val[1]`=85 → no `ack[1]`, outputs 0. After release, `val[1]`=85 still requested → served with `tens`=8, `ones`=5 at the normal latency (cycle 10).

Source files
------------

// File: rtl/bcd_display_sched.sv
// bcd_display_sched: round-robin scheduler that shares one two-digit BCD
// display path among N_REQ requesters. A granted value is captured, converted
// to tens/ones by repeated subtract-by-10, then held for HOLD_CYCLES cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req; grants first set bit from ptr upward
// CONV  | subtract-by-10 loop on the captured value (or saturate if >99)
// HOLD  | result on display, ack/done pulse on entry, dwell HOLD_CYCLES
module bcd_display_sched #(
  parameter int N_REQ       = 4,
  parameter int W           = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     KEY0,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       val,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [3:0]               tens,
  output logic [3:0]               ones,
  output logic                     ovf,
  output logic                     done,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_work;
  logic [3:0]       r_tcnt;
  logic [IW-1:0]    r_ptr;
  logic [HW-1:0]    r_hold;
  logic [IW-1:0]    r_gid;
  logic [N_REQ-1:0] r_ack;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic             w_any;
  logic [IW-1:0]    w_gnt;
  logic [IW-1:0]    w_nptr;
  logic [W-1:0]     w_val;
  logic [8:0]       w_work_ext;
  logic             w_big;
  logic             w_ge10;

  // Round-robin pick: first set req bit scanning upward from ptr, wrapping.
  always_comb begin
    int            v_idx;
    logic [IW-1:0] v_sel;
    w_any = 1'b0;
    w_gnt = '0;
    v_idx = 0;
    v_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = (int'(r_ptr) + k) % N_REQ;
      v_sel = IW'(v_idx);
      if (!w_any && req[v_sel]) begin
        w_any = 1'b1;
        w_gnt = v_sel;
      end
    end
  end

  // Value of the selected requester and the pointer position after it.
  always_comb begin
    w_val = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt == IW'(k)) w_val = val[k*W +: W];
    end
    w_nptr = (int'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + 1'b1;
  end

  // Work register widened so 99 and 10 compare correctly for any W in 4..8.
  assign w_work_ext = {{(9-W){1'b0}}, r_work};
  assign w_big      = (w_work_ext > 9'd99);
  assign w_ge10     = (w_work_ext >= 9'd10);

  // Scheduler FSM with registered display, handshake and status outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_tcnt  <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_gid   <= '0;
      r_ack   <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ack  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_work  <= w_val;
            r_tcnt  <= '0;
            r_gid   <= w_gnt;
            r_ptr   <= w_nptr;
            r_state <= S_CONV;
            r_busy  <= 1'b1;
          end
        end
        S_CONV: begin
          // Only the freshly captured value can exceed 99; after one
          // subtraction the work register is already below 100.
          if (w_big) begin
            r_tens  <= 4'd9;
            r_ones  <= 4'd9;
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_ack   <= N_REQ'(1) << r_gid;
            r_hold  <= HW'(HOLD_CYCLES - 1);
            r_state <= S_HOLD;
          end else if (w_ge10) begin
            r_work <= r_work - W'(10);
            r_tcnt <= r_tcnt + 4'd1;
          end else begin
            r_tens  <= r_tcnt;
            r_ones  <= r_work[3:0];
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
            r_ack   <= N_REQ'(1) << r_gid;
            r_hold  <= HW'(HOLD_CYCLES - 1);
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign grant_id = r_gid;
  assign tens     = r_tens;
  assign ones     = r_ones;
  assign ovf      = r_ovf;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_display_sched.sv
// Testbench for bcd_display_sched: a transaction-level reference model predicts
// each grant's result and done cycle into a queue; a monitor pops and compares.
module tb_bcd_display_sched;

  localparam int N_REQ = 4;
  localparam int W     = 7;
  localparam int H     = 4;
  localparam int IW    = $clog2(N_REQ);

  logic                 CLOCK_50 = 1'b0;
  logic                 KEY0     = 1'b0;
  logic [N_REQ-1:0]     req      = '0;
  logic [N_REQ*W-1:0]   val      = '0;
  logic [N_REQ-1:0]     ack;
  logic [IW-1:0]        grant_id;
  logic [3:0]           tens;
  logic [3:0]           ones;
  logic                 ovf;
  logic                 done;
  logic                 busy;

  bcd_display_sched #(.N_REQ(N_REQ), .W(W), .HOLD_CYCLES(H)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .req      (req),
    .val      (val),
    .ack      (ack),
    .grant_id (grant_id),
    .tens     (tens),
    .ones     (ones),
    .ovf      (ovf),
    .done     (done),
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int g;
    int t;
    int o;
    int ov;
    int at;
  } exp_t;

  exp_t sb_q[$];
  int   obs_gid[$];
  int   served_cnt[N_REQ];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   e_cnt  = 0;
  int   m_ptr  = 0;
  int   m_free = 0;
  int   m_bs   = 1;
  int   m_be   = 0;
  int   m_gid  = 0;
  bit   [N_REQ-1:0] m_insvc = '0;
  int   last_t  = 0;
  int   last_o  = 0;
  int   last_ov = 0;
  bit   drop_on_ack = 1'b1;
  bit   rand_mode   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: at each sampling edge, if the scheduler is free, pick the
  // round-robin winner and predict its digits and done cycle arithmetically.
  initial begin
    forever begin
      @(posedge CLOCK_50);
      if (KEY0 && e_cnt >= m_free && req != '0) begin
        int   g;
        int   v;
        int   lat;
        int   idx;
        exp_t it;
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (g < 0 && req[idx]) g = idx;
        end
        v     = int'(val[g*W +: W]);
        lat   = (v > 99) ? 2 : (v / 10 + 2);
        it.g  = g;
        it.t  = (v > 99) ? 9 : v / 10;
        it.o  = (v > 99) ? 9 : v % 10;
        it.ov = (v > 99) ? 1 : 0;
        it.at = e_cnt + lat;
        sb_q.push_back(it);
        m_ptr    = (g + 1) % N_REQ;
        m_gid    = g;
        m_insvc[g] = 1'b1;
        m_bs     = e_cnt + 1;
        m_be     = e_cnt + lat + H - 1;
        m_free   = e_cnt + lat + H;
      end
      e_cnt++;
    end
  end

  // Monitor: per-cycle status checks, and scoreboard pop on every done.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (KEY0) begin
        chk("busy", 32'(busy), (e_cnt >= m_bs && e_cnt <= m_be) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
          end else begin
            exp_t it;
            it = sb_q.pop_front();
            chk("done_cycle", 32'(e_cnt), 32'(it.at));
            chk("tens", 32'(tens), 32'(it.t));
            chk("ones", 32'(ones), 32'(it.o));
            chk("ovf", 32'(ovf), 32'(it.ov));
            chk("ack", 32'(ack), 32'd1 << it.g);
            last_t  = it.t;
            last_o  = it.o;
            last_ov = it.ov;
            m_insvc[it.g] = 1'b0;
            served_cnt[it.g]++;
            obs_gid.push_back(it.g);
          end
        end else begin
          chk("ack_idle", 32'(ack), 32'd0);
          chk("hold_tens", 32'(tens), 32'(last_t));
          chk("hold_ones", 32'(ones), 32'(last_o));
          chk("hold_ovf", 32'(ovf), 32'(last_ov));
          if (sb_q.size() > 0 && e_cnt > sb_q[0].at) begin
            chk("done_timeout", 32'(done), 32'd1);
            sb_q.delete(0);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  function automatic logic [W-1:0] pick_val();
    int tbl[8] = '{0, 9, 10, 11, 99, 100, 127, 50};
    if ($urandom_range(0, 1) == 0) return W'(tbl[$urandom_range(0, 7)]);
    return W'($urandom_range(0, 127));
  endfunction

  task automatic tick();
    @(negedge CLOCK_50);
    if (KEY0) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i] && drop_on_ack) begin
          req[i] = 1'b0;
        end else if (rand_mode) begin
          if (req[i] && !m_insvc[i] && $urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            val[i*W +: W] = pick_val();
            req[i] = 1'b1;
          end else if (m_insvc[i] && $urandom_range(0, 3) == 0) begin
            val[i*W +: W] = W'($urandom);
          end
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tens"}, 32'(tens), 32'd0);
    chk({tag, "_ones"}, 32'(ones), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_gid"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Reset asserted between edges; outputs checked before any edge arrives.
  task automatic do_reset(input string tag);
    @(negedge CLOCK_50);
    #2;
    KEY0 = 1'b0;
    sb_q.delete();
    m_insvc = '0;
    last_t = 0; last_o = 0; last_ov = 0;
    m_gid = 0; m_ptr = 0; m_free = 0; m_bs = 1; m_be = 0;
    #1;
    check_zero(tag);
    repeat (3) @(negedge CLOCK_50);
    #2;
    KEY0 = 1'b1;
  endtask

  task automatic wait_served(input int i, input int bound);
    int start;
    int n;
    start = served_cnt[i];
    n = 0;
    while (served_cnt[i] == start && n < bound) begin
      tick();
      n++;
    end
    if (served_cnt[i] == start) chk("served_timeout", 32'(served_cnt[i]), 32'(start + 1));
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || req != '0 || e_cnt < m_free) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sb_q.size()) + 32'(req), 32'd0);
  endtask

  initial begin
    int bvals[7] = '{0, 9, 10, 99, 100, 127, 42};
    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    int n;
    for (int i = 0; i < N_REQ; i++) served_cnt[i] = 0;

    repeat (3) @(negedge CLOCK_50);
    #1;
    check_zero("rst_init");
    #1;
    KEY0 = 1'b1;
    repeat (12) tick();

    val[0*W +: W] = W'(57);
    req[0] = 1'b1;
    wait_served(0, 40);
    repeat (H + 2) tick();

    foreach (bvals[b]) begin
      val[2*W +: W] = W'(bvals[b]);
      req[2] = 1'b1;
      wait_served(2, 40);
      repeat (H + 1) tick();
    end

    do_reset("rst_mid");
    repeat (2) tick();

    drop_on_ack = 1'b0;
    obs_gid.delete();
    for (int i = 0; i < N_REQ; i++) val[i*W +: W] = pick_val();
    req = '1;
    n = 0;
    while (obs_gid.size() < 6 && n < 300) begin
      tick();
      n++;
    end
    req = '0;
    drop_on_ack = 1'b1;
    if (obs_gid.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("fair_order", 32'(obs_gid[k]), 32'(fair_exp[k]));
    end else begin
      chk("fair_grants", 32'(obs_gid.size()), 32'd6);
    end
    drain(100);

    val[1*W +: W] = W'(85);
    req[1] = 1'b1;
    n = 0;
    while (!m_insvc[1] && n < 20) begin
      tick();
      n++;
    end
    chk("abort_granted", 32'(m_insvc[1]), 32'd1);
    tick();
    do_reset("rst_abort");
    wait_served(1, 40);
    drain(100);

    rand_mode = 1'b1;
    repeat (1500) tick();
    rand_mode = 1'b0;
    drain(600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
